// File: rtl/count_bus_reader_pkg.sv
// Shared types and defaults for the count bus reader and its counters.
// Latency: none; this file holds only types and constants.
// Backpressure: none; nothing here carries data.
package count_bus_reader_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Reader FSM: waiting for a valid sample, or locked onto the sequence.
    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // How a sampled bus beat is interpreted from its output-enable pattern.
    typedef enum logic [1:0] {
        CLS_IDLE    = 2'd0,
        CLS_VALID   = 2'd1,
        CLS_PARTIAL = 2'd2
    } sample_cls_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
// Latency: count reflects an inc or clr one clock after it is sampled.
// Backpressure: none; every inc is taken, or dropped silently once saturated.
module sat_counter
    import count_bus_reader_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats a same-cycle increment; stop counting at the top value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/count_bus_reader.sv
// Reader for the count bus: locks onto the count, flags jumps, wraps and partial-enable beats.
// Latency: bus beat sampled at edge N; outputs and pulses for it update at edge N+1.
// Backpressure: none; the bus is sampled every cycle and the reader never stalls it.
module count_bus_reader
    import count_bus_reader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_val,
    input  logic [WIDTH-1:0] bus_oe,
    input  logic             clear,
    output logic             locked,
    output logic [WIDTH-1:0] last_val,
    output logic             jump_pulse,
    output logic [WIDTH-1:0] jump_from,
    output logic [WIDTH-1:0] jump_to,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             oe_err
);

    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] s_oe;
    logic [WIDTH-1:0] exp_val;
    sample_cls_t      s_cls;
    state_t           state;
    state_t           state_nxt;
    logic             ev_capture;
    logic             ev_jump;
    logic             ev_wrap;
    logic             ev_err;

    // Input register: the FSM only ever looks at the registered copy of the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_val <= '0;
            s_oe  <= '0;
        end else begin
            s_val <= bus_val;
            s_oe  <= bus_oe;
        end
    end

    // Classify the sampled beat: fully driven, fully released, or torn.
    always_comb begin
        s_cls = CLS_PARTIAL;
        if (&s_oe) begin
            s_cls = CLS_VALID;
        end else if (s_oe == '0) begin
            s_cls = CLS_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and event decode; a held value in TRACK misses exp_val and so counts as a jump.
    always_comb begin
        state_nxt  = state;
        ev_capture = 1'b0;
        ev_jump    = 1'b0;
        ev_wrap    = 1'b0;
        ev_err     = 1'b0;
        case (state)
            IDLE: begin
                if (s_cls == CLS_VALID) begin
                    ev_capture = 1'b1;
                    state_nxt  = TRACK;
                end else if (s_cls == CLS_PARTIAL) begin
                    ev_err = 1'b1;
                end
            end
            TRACK: begin
                if (s_cls == CLS_VALID) begin
                    ev_capture = 1'b1;
                    if (s_val == exp_val) begin
                        // Only an in-sequence step onto zero is a wrap; a load to zero is a jump.
                        ev_wrap = (s_val == '0);
                    end else begin
                        ev_jump = 1'b1;
                    end
                end else if (s_cls == CLS_IDLE) begin
                    state_nxt = IDLE;
                end else begin
                    ev_err    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture registers and single-cycle pulses; jump_from takes last_val before it is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked     <= 1'b0;
            last_val   <= '0;
            exp_val    <= '0;
            jump_from  <= '0;
            jump_to    <= '0;
            jump_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            locked     <= (state_nxt == TRACK);
            jump_pulse <= ev_jump;
            wrap_pulse <= ev_wrap;
            if (ev_capture) begin
                last_val <= s_val;
                exp_val  <= s_val + WIDTH'(1);
            end
            if (ev_jump) begin
                jump_from <= last_val;
                jump_to   <= s_val;
            end
        end
    end

    // Sticky partial-enable flag; clear wins over a same-cycle error.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_err <= 1'b0;
        end else if (clear) begin
            oe_err <= 1'b0;
        end else if (ev_err) begin
            oe_err <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_jump_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ev_jump),
        .clr (clear),
        .cnt (jump_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ev_wrap),
        .clr (clear),
        .cnt (wrap_cnt)
    );

endmodule

// File: tb/tb_count_bus_reader.sv
// Self-checking bench for count_bus_reader: pulse scoreboard plus per-scenario output checks.
// Latency: expects pulses in the cycle after edge N+1 for a beat sampled at edge N.
// Backpressure: none; the bench drives one bus beat per cycle.
module tb_count_bus_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] bus_val;
    logic [7:0] bus_oe;
    logic       locked;
    logic [7:0] last_val;
    logic       jump_pulse;
    logic [7:0] jump_from;
    logic [7:0] jump_to;
    logic       wrap_pulse;
    logic [7:0] jump_cnt;
    logic [7:0] wrap_cnt;
    logic       oe_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        bit         is_jump;
        logic [7:0] from_v;
        logic [7:0] to_v;
        int         at_cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    count_bus_reader #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_val    (bus_val),
        .bus_oe     (bus_oe),
        .clear      (clear),
        .locked     (locked),
        .last_val   (last_val),
        .jump_pulse (jump_pulse),
        .jump_from  (jump_from),
        .jump_to    (jump_to),
        .wrap_pulse (wrap_pulse),
        .jump_cnt   (jump_cnt),
        .wrap_cnt   (wrap_cnt),
        .oe_err     (oe_err)
    );

    // Scoreboard: every observed pulse must match the oldest expected event, cycle included.
    always @(negedge clk) begin
        if (!rst && (jump_pulse || wrap_pulse)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse cyc=%0d jump=%b wrap=%b from=%h to=%h, required no pulse",
                         cyc, jump_pulse, wrap_pulse, jump_from, jump_to);
            end else begin
                mon_e = exp_q.pop_front();
                if (jump_pulse !== mon_e.is_jump || wrap_pulse !== !mon_e.is_jump ||
                    cyc != mon_e.at_cyc ||
                    (mon_e.is_jump && (jump_from !== mon_e.from_v || jump_to !== mon_e.to_v))) begin
                    fails++;
                    $display("FAIL pulse_match got jump=%b wrap=%b from=%h to=%h cyc=%0d, required jump=%b from=%h to=%h cyc=%0d",
                             jump_pulse, wrap_pulse, jump_from, jump_to, cyc,
                             mon_e.is_jump, mon_e.from_v, mon_e.to_v, mon_e.at_cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one beat before the next edge; n is the edge count after it is sampled.
    task automatic drive(input logic [7:0] v, input logic [7:0] oe, output int n);
        @(negedge clk);
        bus_val = v;
        bus_oe  = oe;
        @(posedge clk);
        #1;
        n = cyc;
    endtask

    task automatic push_ev(input bit is_jump, input logic [7:0] f, input logic [7:0] t, input int n);
        exp_q.push_back('{is_jump, f, t, n + 1});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        clear   = 1'b0;
        bus_val = 8'h00;
        bus_oe  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        drive(8'h10, 8'hFF, n);
        drive(8'h11, 8'hFF, n);
        drive(8'h30, 8'hFF, n);
        push_ev(1'b1, 8'h11, 8'h30, n);
        drive(8'h31, 8'hFF, n);
        drive(8'h32, 8'hFF, n);
        tests++; if (locked !== 1'b1 || jump_cnt !== 8'd1) begin fails++;
            $display("FAIL rst_pre got locked=%b jump_cnt=%0d, required 1/1", locked, jump_cnt); end
        @(negedge clk);
        rst = 1'b1; bus_val = 8'h40; bus_oe = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({locked, last_val, jump_from, jump_to, jump_pulse, wrap_pulse, jump_cnt, wrap_cnt, oe_err} !== '0) begin fails++;
            $display("FAIL rst_outputs got locked=%b last=%h from=%h to=%h jp=%b wp=%b jc=%0d wc=%0d err=%b, required all 0",
                     locked, last_val, jump_from, jump_to, jump_pulse, wrap_pulse, jump_cnt, wrap_cnt, oe_err); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (locked !== 1'b0) begin fails++;
            $display("FAIL rst_first_edge got locked=%b, required 0", locked); end
        @(negedge clk);
        bus_oe = 8'h00;
        @(posedge clk); #1;
        tests++; if (locked !== 1'b1 || last_val !== 8'h40) begin fails++;
            $display("FAIL rst_relock got locked=%b last=%h, required 1/40", locked, last_val); end
        repeat (3) drive(8'h00, 8'h00, n);
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL rst_missing_pulse pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_plain_count();
        int n;
        do_reset();
        drive(8'h10, 8'hFF, n);
        tests++; if (locked !== 1'b0) begin fails++;
            $display("FAIL plain_early_lock got locked=%b, required 0", locked); end
        drive(8'h11, 8'hFF, n);
        tests++; if (locked !== 1'b1 || last_val !== 8'h10) begin fails++;
            $display("FAIL plain_lock got locked=%b last=%h, required 1/10", locked, last_val); end
        drive(8'h12, 8'hFF, n);
        drive(8'h13, 8'hFF, n);
        drive(8'h00, 8'h00, n);
        tests++; if (locked !== 1'b1 || last_val !== 8'h13 || jump_cnt !== 8'd0 || wrap_cnt !== 8'd0) begin fails++;
            $display("FAIL plain_end got locked=%b last=%h jc=%0d wc=%0d, required 1/13/0/0",
                     locked, last_val, jump_cnt, wrap_cnt); end
        drive(8'h00, 8'h00, n);
        tests++; if (locked !== 1'b0 || last_val !== 8'h13) begin fails++;
            $display("FAIL plain_unlock got locked=%b last=%h, required 0/13", locked, last_val); end
        repeat (2) drive(8'h00, 8'h00, n);
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL plain_missing_pulse pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_load_jump();
        int n;
        do_reset();
        drive(8'h20, 8'hFF, n);
        drive(8'h21, 8'hFF, n);
        drive(8'h80, 8'hFF, n);
        push_ev(1'b1, 8'h21, 8'h80, n);
        drive(8'h81, 8'hFF, n);
        drive(8'h00, 8'h00, n);
        tests++; if (jump_from !== 8'h21 || jump_to !== 8'h80 || jump_cnt !== 8'd1 || wrap_cnt !== 8'd0 || last_val !== 8'h81) begin fails++;
            $display("FAIL jump_state got from=%h to=%h jc=%0d wc=%0d last=%h, required 21/80/1/0/81",
                     jump_from, jump_to, jump_cnt, wrap_cnt, last_val); end
        repeat (3) drive(8'h00, 8'h00, n);
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL jump_missing_pulse pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        drive(8'hFE, 8'hFF, n);
        drive(8'hFF, 8'hFF, n);
        drive(8'h00, 8'hFF, n);
        push_ev(1'b0, 8'h00, 8'h00, n);
        drive(8'h01, 8'hFF, n);
        drive(8'h00, 8'h00, n);
        tests++; if (wrap_cnt !== 8'd1 || jump_cnt !== 8'd0 || last_val !== 8'h01 || locked !== 1'b1) begin fails++;
            $display("FAIL wrap_state got wc=%0d jc=%0d last=%h locked=%b, required 1/0/01/1",
                     wrap_cnt, jump_cnt, last_val, locked); end
        repeat (3) drive(8'h00, 8'h00, n);
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL wrap_missing_pulse pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_load_zero();
        int n;
        do_reset();
        drive(8'h05, 8'hFF, n);
        drive(8'h06, 8'hFF, n);
        drive(8'h00, 8'hFF, n);
        push_ev(1'b1, 8'h06, 8'h00, n);
        drive(8'h00, 8'h00, n);
        tests++; if (jump_cnt !== 8'd1 || wrap_cnt !== 8'd0 || jump_from !== 8'h06 || jump_to !== 8'h00) begin fails++;
            $display("FAIL zero_load got jc=%0d wc=%0d from=%h to=%h, required 1/0/06/00",
                     jump_cnt, wrap_cnt, jump_from, jump_to); end
        repeat (3) drive(8'h00, 8'h00, n);
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL zero_missing_pulse pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_bad_oe();
        int n;
        do_reset();
        drive(8'h30, 8'hFF, n);
        drive(8'h31, 8'hFF, n);
        tests++; if (oe_err !== 1'b0 || locked !== 1'b1) begin fails++;
            $display("FAIL oe_before got err=%b locked=%b, required 0/1", oe_err, locked); end
        drive(8'h32, 8'h0F, n);
        drive(8'h40, 8'hFF, n);
        tests++; if (oe_err !== 1'b1 || locked !== 1'b0) begin fails++;
            $display("FAIL oe_detect got err=%b locked=%b, required 1/0", oe_err, locked); end
        drive(8'h41, 8'hFF, n);
        drive(8'h00, 8'h00, n);
        tests++; if (oe_err !== 1'b1 || locked !== 1'b1 || last_val !== 8'h41 || jump_cnt !== 8'd0) begin fails++;
            $display("FAIL oe_relock got err=%b locked=%b last=%h jc=%0d, required 1/1/41/0",
                     oe_err, locked, last_val, jump_cnt); end
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        tests++; if (oe_err !== 1'b0 || last_val !== 8'h41) begin fails++;
            $display("FAIL oe_clear got err=%b last=%h, required 0/41", oe_err, last_val); end
        @(negedge clk);
        clear = 1'b0;
        repeat (2) drive(8'h00, 8'h00, n);
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL oe_pulse_pending pending=%0d, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        drive(8'h55, 8'hFF, n);
        for (int i = 0; i < 300; i++) begin
            drive(8'h55, 8'hFF, n);
            push_ev(1'b1, 8'h55, 8'h55, n);
        end
        drive(8'h00, 8'h00, n);
        tests++; if (jump_cnt !== 8'd255 || wrap_cnt !== 8'd0) begin fails++;
            $display("FAIL sat_count got jc=%0d wc=%0d, required 255/0", jump_cnt, wrap_cnt); end
        drive(8'h60, 8'hFF, n);
        drive(8'h60, 8'hFF, n);
        push_ev(1'b1, 8'h60, 8'h60, n);
        @(negedge clk);
        clear  = 1'b1;
        bus_oe = 8'h00;
        @(posedge clk); #1;
        tests++; if (jump_cnt !== 8'd0 || jump_pulse !== 1'b1) begin fails++;
            $display("FAIL sat_clear_beats_inc got jc=%0d jp=%b, required 0/1", jump_cnt, jump_pulse); end
        @(negedge clk);
        clear = 1'b0;
        repeat (3) drive(8'h00, 8'h00, n);
        tests++; if (jump_cnt !== 8'd0 || exp_q.size() != 0) begin fails++;
            $display("FAIL sat_after got jc=%0d pending=%0d, required 0/0", jump_cnt, exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        bus_val = 8'h00;
        bus_oe  = 8'h00;
        test_reset();
        test_plain_count();
        test_load_jump();
        test_wrap();
        test_load_zero();
        test_bad_oe();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
